// File: rtl/weight_loader_conv1.sv
// weight_loader_conv1: forwards one AXI-Stream burst to the conv1 weight-load write port.
// Optional `define WEIGHT_CHECKSUM_EN appends a modulo-2^64 checksum beat to the burst.
module weight_loader_conv1 #(
    parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
    parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned pKERNEL_NUM        = 27,
    parameter int unsigned pBIAS_NUM          = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [pWEIGHT_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic                          load_weight,
    output logic [31:0]                   weight_addr,
    output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [1:0]                    err_code
);

    localparam int unsigned pWORD_NUM = pKERNEL_NUM + pBIAS_NUM + 2;
`ifdef WEIGHT_CHECKSUM_EN
    localparam int unsigned BeatNum = pWORD_NUM + 1;
`else
    localparam int unsigned BeatNum = pWORD_NUM;
`endif
    localparam int unsigned CntW = $clog2(BeatNum + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StErr} state_e;

    state_e                          state_q;
    logic [CntW-1:0]                 cnt_q;
    logic                            load_q;
    logic [31:0]                     addr_q;
    logic [pWEIGHT_DATA_WIDTH-1:0]   data_q;
    logic                            done_q;
    logic                            err_q;
    logic [1:0]                      code_q;
`ifdef WEIGHT_CHECKSUM_EN
    logic [pWEIGHT_DATA_WIDTH-1:0]   sum_q;
`endif

    logic fire;
    logic last_beat;
    logic fwd;

    assign s_axis_tready = (state_q == StLoad);
    assign fire          = s_axis_tvalid && s_axis_tready;
    assign last_beat     = (cnt_q == CntW'(BeatNum - 1));
`ifdef WEIGHT_CHECKSUM_EN
    // The checksum beat is consumed locally and never written to the datapath.
    assign fwd = fire && !last_beat;
`else
    assign fwd = fire;
`endif

    assign load_weight = load_q;
    assign weight_addr = addr_q;
    assign weight_data = data_q;
    assign busy        = (state_q == StLoad);
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
`ifdef WEIGHT_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            load_q <= fwd;
            done_q <= 1'b0;
            if (fwd) begin
                addr_q <= pWEIGHT_BASE_ADDR + 32'(cnt_q);
                data_q <= s_axis_tdata;
            end
            case (state_q)
                StIdle, StErr: begin
                    if (start) begin
                        state_q <= StLoad;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        code_q  <= 2'b00;
`ifdef WEIGHT_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                StLoad: begin
                    if (fire) begin
                        cnt_q <= cnt_q + CntW'(1);
`ifdef WEIGHT_CHECKSUM_EN
                        sum_q <= sum_q + s_axis_tdata;
`endif
                        if (!last_beat) begin
                            if (s_axis_tlast) begin
                                state_q <= StErr;
                                err_q   <= 1'b1;
                                code_q  <= 2'b01;
                            end
                        end else if (!s_axis_tlast) begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                            code_q  <= 2'b10;
                        end else begin
`ifdef WEIGHT_CHECKSUM_EN
                            if (sum_q == s_axis_tdata) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StErr;
                                err_q   <= 1'b1;
                                code_q  <= 2'b11;
                            end
`else
                            state_q <= StDone;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader_conv1.sv
// Directed bench for weight_loader_conv1: nominal, short/long bursts, throttling, resets.
`timescale 1ns/1ps
module tb_weight_loader_conv1;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          NW   = 32;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [63:0] tdata  = '0;
    logic        tvalid = 1'b0;
    logic        tlast  = 1'b0;
    logic        s_axis_tready;
    logic        load_weight;
    logic [31:0] weight_addr;
    logic [63:0] weight_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;
    int wr_n = 0;
    int done_n = 0;
    logic [31:0] wr_addr [0:1023];
    logic [63:0] wr_data [0:1023];

    weight_loader_conv1 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (s_axis_tready),
        .load_weight   (load_weight),
        .weight_addr   (weight_addr),
        .weight_data   (weight_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    // Passive log of every write strobe and done pulse.
    always @(negedge clk) begin
        if (load_weight && wr_n < 1024) begin
            wr_addr[wr_n] = weight_addr;
            wr_data[wr_n] = weight_data;
            wr_n++;
        end
        if (done) done_n++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic l, output logic acc);
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        acc    = s_axis_tready;
        cyc();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_payload(input int n, input int last_at, input bit throttle,
                                output int acc_n);
        logic a;
        acc_n = 0;
        for (int k = 0; k < n; k++) begin
            if (throttle) repeat ($urandom_range(0, 2)) cyc();
            beat(64'(k), (k == last_at), a);
            if (a) acc_n++;
        end
    endtask

    task automatic send_good(input bit throttle, output int acc_n);
`ifdef WEIGHT_CHECKSUM_EN
        logic a;
        send_payload(NW, -1, throttle, acc_n);
        beat(64'd496, 1'b1, a);
        if (a) acc_n++;
`else
        send_payload(NW, NW - 1, throttle, acc_n);
`endif
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({s_axis_tready, load_weight, busy, done, err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {s_axis_tready, load_weight, busy, done, err});
        end
        tests++;
        if (weight_addr !== 32'h0) begin
            fails++; $display("FAIL reset_addr got %h want 0", weight_addr);
        end
        tests++;
        if (weight_data !== 64'h0) begin
            fails++; $display("FAIL reset_data got %h want 0", weight_data);
        end
        tests++;
        if (err_code !== 2'b00) begin
            fails++; $display("FAIL reset_code got %b want 00", err_code);
        end
        #10 rst_n = 1'b1;
        tvalid = 1'b1;
        cyc();
        cyc();
        tvalid = 1'b0;
        tests++;
        if (s_axis_tready !== 1'b0 || wr_n != 0) begin
            fails++; $display("FAIL idle_ignore tready=%b writes=%0d want 0 0", s_axis_tready, wr_n);
        end
    endtask

    task automatic test_nominal();
        int w0, d0, acc;
        w0 = wr_n; d0 = done_n;
        pulse_start();
        tests++;
        if (busy !== 1'b1 || s_axis_tready !== 1'b1) begin
            fails++; $display("FAIL nom_load busy=%b tready=%b want 1 1", busy, s_axis_tready);
        end
        send_good(1'b0, acc);
        tests++;
        if (done !== 1'b1) begin
            fails++; $display("FAIL nom_done got %b want 1", done);
        end
`ifndef WEIGHT_CHECKSUM_EN
        tests++;
        if (load_weight !== 1'b1 || weight_addr !== BASE + 32'd31) begin
            fails++;
            $display("FAIL nom_final load=%b addr=%h want 1 %h", load_weight, weight_addr,
                     BASE + 32'd31);
        end
`endif
        cyc();
        tests++;
        if ({busy, done, err} !== 3'b000) begin
            fails++; $display("FAIL nom_after got %b want 000", {busy, done, err});
        end
        tests++;
        if (wr_n - w0 != NW || done_n - d0 != 1) begin
            fails++;
            $display("FAIL nom_counts writes=%0d dones=%0d want 32 1", wr_n - w0, done_n - d0);
        end
        for (int i = 0; i < NW; i++) begin
            tests++;
            if (wr_addr[w0+i] !== BASE + 32'(i) || wr_data[w0+i] !== 64'(i)) begin
                fails++;
                $display("FAIL nom_write[%0d] addr=%h data=%h want %h %h", i, wr_addr[w0+i],
                         wr_data[w0+i], BASE + 32'(i), 64'(i));
            end
        end
    endtask

    task automatic test_short();
        int w0, d0, acc;
        w0 = wr_n; d0 = done_n;
        pulse_start();
        send_payload(10, 9, 1'b0, acc);
        tests++;
        if ({err, err_code, s_axis_tready, busy} !== 5'b10100) begin
            fails++;
            $display("FAIL short_err err=%b code=%b tready=%b busy=%b want 1 01 0 0",
                     err, err_code, s_axis_tready, busy);
        end
        cyc();
        tests++;
        if (wr_n - w0 != 10 || done_n != d0 || acc != 10) begin
            fails++;
            $display("FAIL short_counts writes=%0d dones=%0d acc=%0d want 10 0 10",
                     wr_n - w0, done_n - d0, acc);
        end
        tests++;
        if (wr_addr[w0+9] !== BASE + 32'd9) begin
            fails++; $display("FAIL short_last_addr got %h want %h", wr_addr[w0+9], BASE + 32'd9);
        end
    endtask

    task automatic test_long();
        int w0, d0, acc;
        logic a;
        w0 = wr_n; d0 = done_n;
        pulse_start();
        tests++;
        if (err !== 1'b0 || err_code !== 2'b00) begin
            fails++; $display("FAIL long_clear err=%b code=%b want 0 00", err, err_code);
        end
        send_payload(NW, -1, 1'b0, acc);
`ifdef WEIGHT_CHECKSUM_EN
        beat(64'd496, 1'b0, a);
        if (a) acc++;
`endif
        beat(64'd999, 1'b1, a);
        tests++;
        if (a !== 1'b0) begin
            fails++; $display("FAIL long_extra_accepted got %b want 0", a);
        end
        cyc();
        tests++;
        if (err !== 1'b1 || err_code !== 2'b10) begin
            fails++; $display("FAIL long_err err=%b code=%b want 1 10", err, err_code);
        end
        tests++;
        if (wr_n - w0 != NW || done_n != d0) begin
            fails++;
            $display("FAIL long_counts writes=%0d dones=%0d want 32 0", wr_n - w0, done_n - d0);
        end
    endtask

    task automatic test_throttled();
        int w0, d0, acc;
        w0 = wr_n; d0 = done_n;
        pulse_start();
        send_good(1'b1, acc);
        cyc();
        tests++;
        if (wr_n - w0 != NW || done_n - d0 != 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL thr_counts writes=%0d dones=%0d err=%b want 32 1 0",
                     wr_n - w0, done_n - d0, err);
        end
        for (int i = 0; i < NW; i++) begin
            tests++;
            if (wr_addr[w0+i] !== BASE + 32'(i) || wr_data[w0+i] !== 64'(i)) begin
                fails++;
                $display("FAIL thr_write[%0d] addr=%h data=%h want %h %h", i, wr_addr[w0+i],
                         wr_data[w0+i], BASE + 32'(i), 64'(i));
            end
        end
    endtask

    task automatic test_err_restart();
        int w0, d0, acc;
        w0 = wr_n; d0 = done_n;
        pulse_start();
        send_payload(3, 2, 1'b0, acc);
        cyc();
        pulse_start();
        send_good(1'b0, acc);
        cyc();
        tests++;
        if (wr_n - w0 != 3 + NW || done_n - d0 != 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL restart_counts writes=%0d dones=%0d err=%b want 35 1 0",
                     wr_n - w0, done_n - d0, err);
        end
        tests++;
        if (wr_addr[w0+3] !== BASE || wr_addr[w0+3+NW-1] !== BASE + 32'd31) begin
            fails++;
            $display("FAIL restart_addr first=%h last=%h want %h %h", wr_addr[w0+3],
                     wr_addr[w0+3+NW-1], BASE, BASE + 32'd31);
        end
    endtask

    task automatic test_reset_mid();
        int w0, d0, acc;
        pulse_start();
        send_payload(15, -1, 1'b0, acc);
        tests++;
        if (load_weight !== 1'b1 || weight_addr !== BASE + 32'd14) begin
            fails++;
            $display("FAIL mid_pre load=%b addr=%h want 1 %h", load_weight, weight_addr,
                     BASE + 32'd14);
        end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({s_axis_tready, load_weight, busy, done, err, err_code} !== 7'b0 ||
            weight_addr !== 32'h0 || weight_data !== 64'h0) begin
            fails++;
            $display("FAIL mid_reset ctrl=%b addr=%h data=%h want 0 0 0",
                     {s_axis_tready, load_weight, busy, done, err, err_code},
                     weight_addr, weight_data);
        end
        #1 rst_n = 1'b1;
        cyc();
        w0 = wr_n; d0 = done_n;
        pulse_start();
        send_good(1'b0, acc);
        cyc();
        tests++;
        if (wr_n - w0 != NW || done_n - d0 != 1) begin
            fails++;
            $display("FAIL mid_reload writes=%0d dones=%0d want 32 1", wr_n - w0, done_n - d0);
        end
        tests++;
        if (wr_addr[w0] !== BASE || wr_data[w0+NW-1] !== 64'd31) begin
            fails++;
            $display("FAIL mid_reload_data addr0=%h data31=%h want %h 1f", wr_addr[w0],
                     wr_data[w0+NW-1], BASE);
        end
    endtask

`ifdef WEIGHT_CHECKSUM_EN
    task automatic test_checksum();
        int w0, d0, acc;
        logic a;
        w0 = wr_n; d0 = done_n;
        pulse_start();
        send_payload(NW, -1, 1'b0, acc);
        beat(64'd497, 1'b1, a);
        tests++;
        if (err !== 1'b1 || err_code !== 2'b11) begin
            fails++; $display("FAIL cksum_bad err=%b code=%b want 1 11", err, err_code);
        end
        cyc();
        tests++;
        if (wr_n - w0 != NW || done_n != d0) begin
            fails++;
            $display("FAIL cksum_bad_counts writes=%0d dones=%0d want 32 0",
                     wr_n - w0, done_n - d0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_throttled();
        test_err_restart();
        test_reset_mid();
`ifdef WEIGHT_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/weight_loader_conv1.md
Name: weight_loader_conv1

Overview:
- Stream-to-register-bus transmitter that drives the weight-load write port (load_weight / weight_addr / weight_data) of the conv1 MAC datapath.
- Accepts a single AXI-Stream burst of 64-bit words and assigns each word a sequential address from pWEIGHT_BASE_ADDR, covering the image kernels → biases → dequant scale → output scale.
- Checks burst length against the expected image size, then reports done or error to the layer controller.

Parameters:
pWEIGHT_DATA_WIDTH  64             width of one weight word
pWEIGHT_BASE_ADDR   32'h4000_0000  address of first kernel word
pKERNEL_NUM         27             kernel words
pBIAS_NUM           3              bias words
pWORD_NUM (local)   pKERNEL_NUM+pBIAS_NUM+2  payload words (kernels, biases, scale, scale_out)

Ports:
clk            in   1                      clock
rst_n          in   1                      asynchronous active-low reset
start          in   1                      pulse; begin a load sequence
s_axis_tdata   in   pWEIGHT_DATA_WIDTH     weight word
s_axis_tvalid  in   1                      word valid
s_axis_tlast   in   1                      final word of burst
s_axis_tready  out  1                      word accepted when tvalid&&tready
load_weight    out  1                      one-cycle write strobe per word
weight_addr    out  32                     write address
weight_data    out  pWEIGHT_DATA_WIDTH     write data
busy           out  1                      high in LOAD
done           out  1                      one-cycle pulse on successful load
err            out  1                      sticky error flag
err_code       out  2                      01 short burst, 10 long burst, 11 checksum

Behaviour:
- Interface fixed: one clock clk, asynchronous active-low reset rst_n.
- Reset (async, immediate): state IDLE; all outputs 0; word counter 0; err_code 00.
- States: IDLE, LOAD, DONE, ERR.
- IDLE:
  - tready=0.
  - start=1 → LOAD; counter cleared; err and err_code cleared.
- LOAD:
  - tready=1 combinationally from state.
  - Consumer has no backpressure, so tready never drops mid-burst.
  - Each accepted beat k (0-based): next cycle load_weight=1, weight_addr=pWEIGHT_BASE_ADDR+k, weight_data=tdata. Output latency exactly 1 cycle.
  - Output registers hold last value when load_weight=0.
  - Counter increments per accepted beat.
  - tlast on beat k<pWORD_NUM-1: beat is still forwarded, then → ERR, err_code=01.
  - Beat pWORD_NUM-1 with tlast=1 → DONE.
  - Beat pWORD_NUM-1 with tlast=0: beat is forwarded, then → ERR, err_code=10; further beats are not accepted.
  - start while in LOAD is ignored.
- DONE: done=1 for exactly one cycle (the cycle the final load_weight is high); → IDLE next cycle.
- ERR:
  - tready=0; err=1 and err_code held.
  - start → LOAD with counter, err and err_code cleared.
- Simultaneous start and reset: reset wins.
- tvalid without tready (IDLE/ERR): ignored, nothing forwarded.
- Address arithmetic is 32-bit unsigned; no wrap checking (base+pWORD_NUM must not overflow).
- busy=1 only in LOAD.

Optional Feature:
- Macro WEIGHT_CHECKSUM_EN defined:
  - Burst is pWORD_NUM+1 beats; tlast is expected on beat pWORD_NUM.
  - Payload beats keep a modulo-2^64 running sum, cleared on start.
  - The final beat carries the expected sum; it is never forwarded (no load_weight).
  - Match → DONE. Mismatch → ERR, err_code=11.
  - Short/long detection rules apply against pWORD_NUM+1.
- Macro not defined: burst is pWORD_NUM beats, no sum logic, err_code 11 never generated.

Test Plan:
- Nominal: start, 32 beats tdata=k, tlast on beat 31 → 32 load_weight pulses, addr 0x4000_0000..0x4000_001F, data 0..31, done pulses once, err=0.
- Short burst: tlast on beat 9 → 10 writes (addr up to 0x4000_0009), err=1, err_code=01, tready=0, no done.
- Long burst: beat 31 with tlast=0 → 32 writes, err_code=10, tready drops, beat 32 not accepted.
- Throttled source: tvalid toggled randomly over 32 beats → writes contiguous in addr order, none duplicated or skipped; error then start → fresh load from 0x4000_0000 completes.
- Reset at beat 15 → all outputs 0 immediately; next start reloads from 0x4000_0000.
- WEIGHT_CHECKSUM_EN: 33rd beat=496 (sum of 0..31) → done, 32 writes. 33rd beat=497 → err_code=11, still 32 writes, no done.
